gpio_bank_regs: RTL and testbench

- Parametrised successor to the fixed two-connector GPIO register decoder.
- Provides N generic 24-bit GPIO ports on the reg_clk register bus, each with data, DDR and open-drain registers.
- Adds atomic set/clear writes, synchronised inputs, per-bit rising/falling edge capture with write-1-to-clear status, a level interrupt, and an explicit read-data-valid strobe.
- Sits between the HPS register bridge and the pin drivers; unmapped reads pass through hm2 bus data.

---
 rtl/gpio_bank_regs.sv | 173 +++++++++++++++++
 tb/tb_gpio_bank_regs.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bank_regs.sv
// gpio_bank_regs: N-port GPIO register bank with set/clear, synchronised inputs, edge capture and irq
module gpio_bank_regs #(
    parameter int AddrWidth = 16,
    parameter int BusWidth = 32,
    parameter int RegWidth = 24,
    parameter int NumPorts = 6,
    parameter logic [AddrWidth-1:0] BaseAddr = 16'h1000,
    parameter int SyncStages = 2
) (
    input  logic reg_clk,
    input  logic reset_in,
    input  logic read_reg,
    input  logic write_reg,
    input  logic [AddrWidth-3:0] busaddress,
    input  logic [BusWidth-1:0] busdata_in,
    input  logic [BusWidth-1:0] busdata_fromhm2,
    input  logic [NumPorts*RegWidth-1:0] gpio_in,
    output logic [NumPorts*RegWidth-1:0] gpio_out,
    output logic [NumPorts*RegWidth-1:0] gpio_oe,
    output logic [BusWidth-1:0] busdata_to_cpu,
    output logic read_valid,
    output logic irq
);
    localparam int NW = NumPorts * RegWidth;
    localparam int RgW = AddrWidth - 7;
    localparam logic [RgW-1:0] R_DATA = RgW'(0);
    localparam logic [RgW-1:0] R_DDR = RgW'(2);
    localparam logic [RgW-1:0] R_OD = RgW'(6);
    localparam logic [RgW-1:0] R_SET = RgW'(8);
    localparam logic [RgW-1:0] R_CLR = RgW'(9);
    localparam logic [RgW-1:0] R_RISE = RgW'(10);
    localparam logic [RgW-1:0] R_FALL = RgW'(11);
    localparam logic [RgW-1:0] R_EDGE = RgW'(12);

    logic wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
    logic [AddrWidth-3:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [RegWidth-1:0] wr_data_q, wr_data_d;
    logic [NW-1:0] out_q, out_d, ddr_q, ddr_d, od_q, od_d;
    logic [NW-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [NW-1:0] edge_stat_q, edge_stat_d;
    logic [NW-1:0] gpio_out_q, gpio_out_d, gpio_oe_q, gpio_oe_d;
    logic [SyncStages-1:0][NW-1:0] sync_q, sync_d;
    logic [NW-1:0] prev_q, prev_d;
    logic [BusWidth-1:0] busdata_q, busdata_d;
    logic read_valid_q, read_valid_d, irq_q, irq_d;
    logic [AddrWidth-1:0] wr_off, rd_off;
    logic [RgW-1:0] wr_rgn, rd_rgn;
    logic [4:0] wr_port, rd_port;
    logic [NW-1:0] sync, rise, fall, clr_mask;
    logic [RegWidth-1:0] rd_word;
    logic rd_mapped;
    logic unused_ok;

    assign wr_off = {wr_addr_q, 2'b00} - BaseAddr;
    assign rd_off = {rd_addr_q, 2'b00} - BaseAddr;
    assign wr_rgn = wr_off[AddrWidth-1:7];
    assign rd_rgn = rd_off[AddrWidth-1:7];
    assign wr_port = wr_off[6:2];
    assign rd_port = rd_off[6:2];
    assign sync = sync_q[SyncStages-1];
    assign rise = sync & ~prev_q & rise_en_q;
    assign fall = ~sync & prev_q & fall_en_q;
    assign unused_ok = ^{busdata_in, wr_off[1:0], rd_off[1:0]};

    assign gpio_out = gpio_out_q;
    assign gpio_oe = gpio_oe_q;
    assign busdata_to_cpu = busdata_q;
    assign read_valid = read_valid_q;
    assign irq = irq_q;

    // Stage 0: capture strobes; a write in the same cycle as a read drops the read
    always_comb begin
        wr_pend_d = write_reg;
        rd_pend_d = read_reg & ~write_reg;
        wr_addr_d = write_reg ? busaddress : wr_addr_q;
        rd_addr_d = read_reg ? busaddress : rd_addr_q;
        wr_data_d = write_reg ? busdata_in[RegWidth-1:0] : wr_data_q;
    end

    // Stage 1 write: update the addressed port register; edge capture beats W1C on the same bit
    always_comb begin
        out_d = out_q;
        ddr_d = ddr_q;
        od_d = od_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr_mask = '0;
        for (int p = 0; p < NumPorts; p++) begin
            if (wr_pend_q && wr_port == 5'(p)) begin
                out_d[p*RegWidth +: RegWidth] = wr_rgn == R_DATA ? wr_data_q
                    : wr_rgn == R_SET ? out_q[p*RegWidth +: RegWidth] | wr_data_q
                    : wr_rgn == R_CLR ? out_q[p*RegWidth +: RegWidth] & ~wr_data_q
                    : out_q[p*RegWidth +: RegWidth];
                ddr_d[p*RegWidth +: RegWidth] = wr_rgn == R_DDR ? wr_data_q : ddr_q[p*RegWidth +: RegWidth];
                od_d[p*RegWidth +: RegWidth] = wr_rgn == R_OD ? wr_data_q : od_q[p*RegWidth +: RegWidth];
                rise_en_d[p*RegWidth +: RegWidth] = wr_rgn == R_RISE ? wr_data_q : rise_en_q[p*RegWidth +: RegWidth];
                fall_en_d[p*RegWidth +: RegWidth] = wr_rgn == R_FALL ? wr_data_q : fall_en_q[p*RegWidth +: RegWidth];
                clr_mask[p*RegWidth +: RegWidth] = wr_rgn == R_EDGE ? wr_data_q : '0;
            end
        end
        edge_stat_d = (edge_stat_q & ~clr_mask) | rise | fall;
    end

    // Pin drivers registered from the next register values so they track the register update
    always_comb begin
        gpio_out_d = out_d & ~od_d;
        gpio_oe_d = (od_d & ~out_d) | (~od_d & ddr_d);
        sync_d = {sync_q[SyncStages-2:0], gpio_in};
        prev_d = sync;
        irq_d = |edge_stat_q;
    end

    // Stage 1 read: select the addressed register, fall back to hm2 data outside the map
    always_comb begin
        rd_word = '0;
        for (int p = 0; p < NumPorts; p++) begin
            if (rd_port == 5'(p))
                rd_word = rd_rgn == R_DATA ? sync[p*RegWidth +: RegWidth]
                    : rd_rgn == R_DDR ? ddr_q[p*RegWidth +: RegWidth]
                    : rd_rgn == R_OD ? od_q[p*RegWidth +: RegWidth]
                    : rd_rgn == R_RISE ? rise_en_q[p*RegWidth +: RegWidth]
                    : rd_rgn == R_FALL ? fall_en_q[p*RegWidth +: RegWidth]
                    : rd_rgn == R_EDGE ? edge_stat_q[p*RegWidth +: RegWidth]
                    : '0;
        end
        rd_mapped = rd_rgn inside {R_DATA, R_DDR, R_OD, R_SET, R_CLR, R_RISE, R_FALL, R_EDGE};
        busdata_d = !rd_pend_q ? busdata_q : rd_mapped ? BusWidth'(rd_word) : busdata_fromhm2;
        read_valid_d = rd_pend_q;
    end

    // State registers; reset aborts any in-flight transaction
    always_ff @(posedge reg_clk or posedge reset_in) begin
        if (reset_in) begin
            wr_pend_q <= 1'b0;
            rd_pend_q <= 1'b0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            wr_data_q <= '0;
            out_q <= '0;
            ddr_q <= '0;
            od_q <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            edge_stat_q <= '0;
            gpio_out_q <= '0;
            gpio_oe_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
            busdata_q <= '0;
            read_valid_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            wr_pend_q <= wr_pend_d;
            rd_pend_q <= rd_pend_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            wr_data_q <= wr_data_d;
            out_q <= out_d;
            ddr_q <= ddr_d;
            od_q <= od_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            edge_stat_q <= edge_stat_d;
            gpio_out_q <= gpio_out_d;
            gpio_oe_q <= gpio_oe_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
            busdata_q <= busdata_d;
            read_valid_q <= read_valid_d;
            irq_q <= irq_d;
        end
    end
endmodule

// File: tb/tb_gpio_bank_regs.sv
// tb_gpio_bank_regs: directed and randomized checks of gpio_bank_regs against a behavioural model
module tb_gpio_bank_regs;
    localparam int NP = 6;
    localparam int RW = 24;
    localparam int NW = NP * RW;
    localparam int S = 2;
    localparam int BASE = 'h1000;
    typedef logic [NW-1:0] vec_t;

    logic reg_clk, reset_in, read_reg, write_reg;
    logic [13:0] busaddress;
    logic [31:0] busdata_in, busdata_fromhm2, busdata_to_cpu;
    logic [NW-1:0] gpio_in, gpio_out, gpio_oe;
    logic read_valid, irq;
    int vectors = 0;
    int miscompares = 0;
    logic [RW-1:0] m_out[NP], m_ddr[NP], m_od[NP], m_re[NP], m_fe[NP], m_es[NP];
    vec_t hist[$];
    int roff[11] = '{'h000, 'h100, 'h300, 'h400, 'h480, 'h500, 'h580, 'h600, 'h080, 'h1000, -256};

    gpio_bank_regs #(
        .AddrWidth(16), .BusWidth(32), .RegWidth(RW), .NumPorts(NP),
        .BaseAddr(16'h1000), .SyncStages(S)
    ) dut (
        .reg_clk(reg_clk),
        .reset_in(reset_in),
        .read_reg(read_reg),
        .write_reg(write_reg),
        .busaddress(busaddress),
        .busdata_in(busdata_in),
        .busdata_fromhm2(busdata_fromhm2),
        .gpio_in(gpio_in),
        .gpio_out(gpio_out),
        .gpio_oe(gpio_oe),
        .busdata_to_cpu(busdata_to_cpu),
        .read_valid(read_valid),
        .irq(irq)
    );

    initial reg_clk = 1'b0;
    always #5 reg_clk = ~reg_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input vec_t obs, input vec_t want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    function automatic logic [15:0] addr_of(input int k, input int p);
        return 16'(BASE + roff[k] + 4 * p);
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_out[p] = '0; m_ddr[p] = '0; m_od[p] = '0;
            m_re[p] = '0; m_fe[p] = '0; m_es[p] = '0;
        end
    endtask

    task automatic model_write(input int k, input int p, input logic [31:0] d);
        logic [RW-1:0] w;
        w = d[RW-1:0];
        if (k <= 7 && p < NP)
            case (k)
                0: m_out[p] = w;
                1: m_ddr[p] = w;
                2: m_od[p] = w;
                3: m_out[p] = m_out[p] | w;
                4: m_out[p] = m_out[p] & ~w;
                5: m_re[p] = w;
                6: m_fe[p] = w;
                default: m_es[p] = m_es[p] & ~w;
            endcase
    endtask

    function automatic logic [31:0] model_read(input int k, input int p, input logic [31:0] hm2);
        logic [RW-1:0] r;
        if (k > 7) return hm2;
        if (p >= NP) return 32'h0;
        case (k)
            0: r = gpio_in[p*RW +: RW];
            1: r = m_ddr[p];
            2: r = m_od[p];
            5: r = m_re[p];
            6: r = m_fe[p];
            7: r = m_es[p];
            default: r = '0;
        endcase
        return {8'h00, r};
    endfunction

    function automatic vec_t exp_out();
        vec_t v;
        for (int p = 0; p < NP; p++)
            for (int b = 0; b < RW; b++)
                v[p*RW+b] = m_od[p][b] ? 1'b0 : m_out[p][b];
        return v;
    endfunction

    function automatic vec_t exp_oe();
        vec_t v;
        for (int p = 0; p < NP; p++)
            for (int b = 0; b < RW; b++)
                v[p*RW+b] = m_od[p][b] ? !m_out[p][b] : m_ddr[p][b];
        return v;
    endfunction

    function automatic logic any_es();
        logic r;
        r = 1'b0;
        for (int p = 0; p < NP; p++) r = r | (|m_es[p]);
        return r;
    endfunction

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        busaddress = a[15:2];
        busdata_in = d;
        write_reg = 1'b1;
        @(negedge reg_clk);
        write_reg = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [31:0] hm2, input logic [31:0] want, input string tag);
        busaddress = a[15:2];
        busdata_fromhm2 = hm2;
        read_reg = 1'b1;
        @(negedge reg_clk);
        read_reg = 1'b0;
        check({tag, " early"}, vec_t'(read_valid), 0);
        @(negedge reg_clk);
        check({tag, " valid"}, vec_t'(read_valid), 1);
        check({tag, " data"}, vec_t'(busdata_to_cpu), vec_t'(want));
        @(negedge reg_clk);
        check({tag, " pulse"}, vec_t'(read_valid), 0);
    endtask

    // One clock of the pin-history model: a bit's edge is seen S cycles after it reaches the pin
    task automatic tick();
        vec_t sy, pv;
        @(posedge reg_clk);
        hist.push_front(gpio_in);
        if (hist.size() > S + 2) void'(hist.pop_back());
        sy = hist[S];
        pv = hist[S+1];
        for (int p = 0; p < NP; p++)
            for (int b = 0; b < RW; b++)
                if ((sy[p*RW+b] && !pv[p*RW+b] && m_re[p][b]) || (!sy[p*RW+b] && pv[p*RW+b] && m_fe[p][b]))
                    m_es[p][b] = 1'b1;
        @(negedge reg_clk);
    endtask

    initial begin
        int k, p;
        logic [31:0] d;
        logic [15:0] a;
        reset_in = 1'b1;
        read_reg = 1'b0;
        write_reg = 1'b0;
        busaddress = '0;
        busdata_in = '0;
        busdata_fromhm2 = '0;
        gpio_in = '0;
        model_reset();
        repeat (3) @(negedge reg_clk);
        check("reset gpio_out", gpio_out, 0);
        check("reset gpio_oe", gpio_oe, 0);
        check("reset busdata", vec_t'(busdata_to_cpu), 0);
        check("reset read_valid", vec_t'(read_valid), 0);
        check("reset irq", vec_t'(irq), 0);
        reset_in = 1'b0;
        @(negedge reg_clk);
        bus_read(16'h1100, 32'h13572468, 32'h0, "ddr0 after reset");
        check("oe after reset", gpio_oe, 0);

        bus_write(16'h1000, 32'h00A5A5A5);
        model_write(0, 0, 32'h00A5A5A5);
        check("data0 not early", gpio_out, 0);
        @(negedge reg_clk);
        check("data0 gpio_out", gpio_out, exp_out());
        bus_write(16'h1100, 32'hFFFFFFFF);
        model_write(1, 0, 32'hFFFFFFFF);
        check("ddr0 not early", gpio_oe, 0);
        @(negedge reg_clk);
        check("ddr0 gpio_oe", gpio_oe, exp_oe());
        bus_read(16'h1100, 32'h0, 32'h00FFFFFF, "ddr0 readback");

        bus_write(16'h1404, 32'h00000011);
        model_write(3, 1, 32'h00000011);
        bus_write(16'h1484, 32'h00000001);
        model_write(4, 1, 32'h00000001);
        @(negedge reg_clk);
        check("set/clr p1 out", gpio_out, exp_out());
        check("set/clr p1 bits", vec_t'(gpio_out[47:24]), 'h10);
        bus_write(16'h1304, 32'h00000010);
        model_write(2, 1, 32'h00000010);
        @(negedge reg_clk);
        check("od p1 oe28", vec_t'(gpio_oe[28]), 0);
        check("od p1 out28", vec_t'(gpio_out[28]), 0);
        check("od p1 oe", gpio_oe, exp_oe());
        bus_write(16'h1484, 32'h00000010);
        model_write(4, 1, 32'h00000010);
        @(negedge reg_clk);
        check("od clr oe28", vec_t'(gpio_oe[28]), 1);
        check("od clr out28", vec_t'(gpio_out[28]), 0);
        check("od clr out", gpio_out, exp_out());

        bus_write(16'h1500, 32'h00000001);
        model_write(5, 0, 32'h00000001);
        @(negedge reg_clk);
        gpio_in[0] = 1'b1;
        @(negedge reg_clk);
        @(negedge reg_clk);
        check("rise irq idle", vec_t'(irq), 0);
        @(negedge reg_clk);
        check("rise irq lags stat", vec_t'(irq), 0);
        @(negedge reg_clk);
        check("rise irq set", vec_t'(irq), 1);
        m_es[0] = 24'h1;
        bus_read(16'h1600, 32'h0, 32'h00000001, "edge stat p0");
        bus_write(16'h1600, 32'h00000001);
        model_write(7, 0, 32'h00000001);
        @(negedge reg_clk);
        check("w1c irq holds", vec_t'(irq), 1);
        @(negedge reg_clk);
        check("w1c irq clear", vec_t'(irq), 0);
        gpio_in[0] = 1'b0;
        repeat (5) @(negedge reg_clk);
        gpio_in[0] = 1'b1;
        @(negedge reg_clk);
        bus_write(16'h1600, 32'h00000001);
        m_es[0] = 24'h1;
        repeat (2) @(negedge reg_clk);
        check("edge wins irq", vec_t'(irq), 1);
        bus_read(16'h1600, 32'h0, 32'h00000001, "edge wins stat");
        bus_write(16'h1600, 32'h00FFFFFF);
        model_write(7, 0, 32'h00FFFFFF);
        bus_write(16'h1500, 32'h0);
        model_write(5, 0, 32'h0);
        repeat (2) @(negedge reg_clk);
        check("edge cleared irq", vec_t'(irq), 0);

        a = 16'h1100;
        busaddress = a[15:2];
        busdata_in = 32'h00123456;
        write_reg = 1'b1;
        read_reg = 1'b1;
        @(negedge reg_clk);
        write_reg = 1'b0;
        read_reg = 1'b0;
        model_write(1, 0, 32'h00123456);
        check("rw clash no valid 1", vec_t'(read_valid), 0);
        @(negedge reg_clk);
        check("rw clash no valid 2", vec_t'(read_valid), 0);
        check("rw clash write", gpio_oe, exp_oe());
        @(negedge reg_clk);
        check("rw clash no valid 3", vec_t'(read_valid), 0);
        bus_read(16'h2000, 32'hDEADBEEF, 32'hDEADBEEF, "unmapped hm2");
        bus_read(16'(BASE + 4 * NP), 32'hCAFEF00D, 32'h0, "port out of range");

        for (int q = 0; q < NP; q++) gpio_in[q*RW +: RW] = RW'($urandom);
        repeat (S + 4) @(negedge reg_clk);
        for (int i = 0; i < 120; i++) begin
            k = int'($urandom_range(0, 10));
            p = int'($urandom_range(0, 7));
            d = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                bus_write(addr_of(k, p), d);
                model_write(k, p, d);
                @(negedge reg_clk);
                check("rnd gpio_out", gpio_out, exp_out());
                check("rnd gpio_oe", gpio_oe, exp_oe());
            end else begin
                bus_read(addr_of(k, p), d, model_read(k, p, d), "rnd read");
            end
        end

        for (int q = 0; q < NP; q++) begin
            d = $urandom;
            bus_write(addr_of(5, q), d);
            model_write(5, q, d);
            d = $urandom;
            bus_write(addr_of(6, q), d);
            model_write(6, q, d);
        end
        repeat (2) @(negedge reg_clk);
        hist.delete();
        repeat (S + 2) hist.push_back(gpio_in);
        for (int i = 0; i < 30; i++) begin
            for (int q = 0; q < NP; q++) gpio_in[q*RW +: RW] = RW'($urandom);
            tick();
        end
        repeat (S + 3) tick();
        check("rnd edge irq", vec_t'(irq), vec_t'(any_es()));
        for (int q = 0; q < NP; q++) bus_read(addr_of(7, q), 32'h0, model_read(7, q, 32'h0), "rnd edge stat");
        for (int q = 0; q < NP; q++) begin
            bus_write(addr_of(7, q), 32'h00FFFFFF);
            model_write(7, q, 32'h00FFFFFF);
        end
        repeat (2) @(negedge reg_clk);
        check("rnd edge irq cleared", vec_t'(irq), 0);

        a = 16'h1100;
        busaddress = a[15:2];
        busdata_in = 32'h00FFFFFF;
        write_reg = 1'b1;
        @(negedge reg_clk);
        write_reg = 1'b0;
        reset_in = 1'b1;
        @(negedge reg_clk);
        reset_in = 1'b0;
        model_reset();
        repeat (2) @(negedge reg_clk);
        check("abort write oe", gpio_oe, 0);
        check("abort write out", gpio_out, 0);
        bus_read(16'h1100, 32'h0, 32'h0, "abort write ddr0");
        bus_read(16'h1000, 32'h0, model_read(0, 0, 32'h0), "data after reset");
        a = 16'h1000;
        busaddress = a[15:2];
        read_reg = 1'b1;
        @(negedge reg_clk);
        read_reg = 1'b0;
        reset_in = 1'b1;
        @(negedge reg_clk);
        check("abort read valid 1", vec_t'(read_valid), 0);
        reset_in = 1'b0;
        @(negedge reg_clk);
        check("abort read valid 2", vec_t'(read_valid), 0);
        check("abort read data", vec_t'(busdata_to_cpu), 0);
        @(negedge reg_clk);
        check("abort read valid 3", vec_t'(read_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
